// File: rtl/ucdp_sfifo.sv
// Single-clock first-word-fall-through FIFO of arbitrary depth.
// Provides level, almost-full/almost-empty flags, a flush, and sticky overflow/underflow flags.
module ucdp_sfifo #(
   parameter int unsigned dwidth_p        = 8,
   parameter int unsigned depth_p         = 4,
   parameter int unsigned lwidth_p        = $clog2(depth_p + 1),
   parameter int unsigned afull_thresh_p  = depth_p - 1,
   parameter int unsigned aempty_thresh_p = 1
) (
   input  logic                main_clk_i,
   input  logic                main_rst_an_i,
   input  logic                flush_i,
   input  logic                err_clr_i,
   input  logic                wr_en_i,
   input  logic [dwidth_p-1:0] wr_data_i,
   output logic                full_o,
   output logic                afull_o,
   output logic [lwidth_p-1:0] space_avail_o,
   input  logic                rd_en_i,
   output logic [dwidth_p-1:0] rd_data_o,
   output logic                empty_o,
   output logic                aempty_o,
   output logic [lwidth_p-1:0] level_o,
   output logic                overflow_o,
   output logic                underflow_o
);

   localparam int unsigned pwidth_lp = $clog2(depth_p);

   typedef logic [pwidth_lp-1:0] ptr_t;
   typedef logic [lwidth_p-1:0]  lvl_t;

   localparam ptr_t last_ptr_lp   = ptr_t'(depth_p - 1);
   localparam lvl_t depth_lvl_lp  = lvl_t'(depth_p);
   localparam lvl_t afull_lvl_lp  = lvl_t'(afull_thresh_p);
   localparam lvl_t aempty_lvl_lp = lvl_t'(aempty_thresh_p);

   logic [dwidth_p-1:0] mem_q [depth_p];

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   lvl_t level_q, level_d;
   lvl_t space_q, space_d;
   logic full_q, full_d;
   logic empty_q, empty_d;
   logic afull_q, afull_d;
   logic aempty_q, aempty_d;
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;
   logic wr_acc, rd_acc, mem_we;

   always_comb begin
      // Accept decisions look only at registered flags, so a full FIFO rejects a write
      // even when a read frees an entry in the same cycle.
      wr_acc   = wr_en_i & ~full_q;
      rd_acc   = rd_en_i & ~empty_q;
      mem_we   = wr_acc & ~flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_t'(1);
         end
         if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_t'(1);
         end
         level_d = level_q + lvl_t'(wr_acc) - lvl_t'(rd_acc);
      end
      full_d   = (level_d == depth_lvl_lp);
      empty_d  = (level_d == '0);
      afull_d  = (level_d >= afull_lvl_lp);
      aempty_d = (level_d <= aempty_lvl_lp);
      space_d  = depth_lvl_lp - level_d;
      // Set beats clear; a request discarded by flush never counts as an error.
      ovf_d    = (~flush_i & wr_en_i & full_q) | (ovf_q & ~err_clr_i);
      unf_d    = (~flush_i & rd_en_i & empty_q) | (unf_q & ~err_clr_i);
   end

   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         space_q  <= depth_lvl_lp;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         space_q  <= space_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   always_ff @(posedge main_clk_i) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign rd_data_o     = mem_q[rd_ptr_q];
   assign full_o        = full_q;
   assign empty_o       = empty_q;
   assign afull_o       = afull_q;
   assign aempty_o      = aempty_q;
   assign space_avail_o = space_q;
   assign level_o       = level_q;
   assign overflow_o    = ovf_q;
   assign underflow_o   = unf_q;

`ifndef SYNTHESIS
   a_params: assert property (@(posedge main_clk_i)
      (dwidth_p >= 1) && (depth_p >= 2) && (depth_p < (1 << lwidth_p)) &&
      (afull_thresh_p >= 1) && (afull_thresh_p <= depth_p) &&
      (aempty_thresh_p <= depth_p - 1));
   a_level: assert property (@(posedge main_clk_i) disable iff (!main_rst_an_i)
      level_o <= depth_lvl_lp);
   a_full_empty: assert property (@(posedge main_clk_i) disable iff (!main_rst_an_i)
      !(full_o && empty_o));
`endif

endmodule

// File: tb/tb_ucdp_sfifo.sv
// Directed bench for ucdp_sfifo at depth 5: fill/drain, wrap, concurrent access,
// thresholds, flush, error flags and asynchronous reset.
module tb_ucdp_sfifo;

   localparam int unsigned DW = 8;
   localparam int unsigned DEPTH = 5;
   localparam int unsigned LW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush, err_clr, wr_en, rd_en;
   logic [DW-1:0] wr_data, rd_data;
   logic          full, afull, empty, aempty, ovf, unf;
   logic [LW-1:0] space, level;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ucdp_sfifo #(
      .dwidth_p(DW),
      .depth_p(DEPTH),
      .lwidth_p(LW),
      .afull_thresh_p(4),
      .aempty_thresh_p(1)
   ) dut (
      .main_clk_i(clk),
      .main_rst_an_i(rst_n),
      .flush_i(flush),
      .err_clr_i(err_clr),
      .wr_en_i(wr_en),
      .wr_data_i(wr_data),
      .full_o(full),
      .afull_o(afull),
      .space_avail_o(space),
      .rd_en_i(rd_en),
      .rd_data_o(rd_data),
      .empty_o(empty),
      .aempty_o(aempty),
      .level_o(level),
      .overflow_o(ovf),
      .underflow_o(unf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; err_clr = 0; wr_en = 0; rd_en = 0;
   endtask

   task automatic push(input logic [DW-1:0] d);
      wr_en = 1; wr_data = d;
      tick();
      wr_en = 0;
   endtask

   task automatic pop_check(input string tag, input logic [DW-1:0] exp);
      check(tag, rd_data, exp);
      rd_en = 1;
      tick();
      rd_en = 0;
   endtask

   // Level-derived flags for the configured depth 5, afull 4, aempty 1.
   task automatic check_level(input string tag, input int lv);
      check({tag, "_level"}, level, lv);
      check({tag, "_space"}, space, 5 - lv);
      check({tag, "_full"}, full, lv == 5);
      check({tag, "_empty"}, empty, lv == 0);
      check({tag, "_afull"}, afull, lv >= 4);
      check({tag, "_aempty"}, aempty, lv <= 1);
   endtask

   initial begin
      rst_n = 0;
      idle();
      wr_data = '0;
      #12;
      check_level("reset", 0);
      check("reset_ovf", ovf, 0);
      check("reset_unf", unf, 0);
      #4 rst_n = 1;

      // Fill and drain
      for (int i = 0; i < 5; i++) begin
         push(8'h10 + 8'(i));
         check_level("fill", i + 1);
      end
      for (int i = 0; i < 5; i++) begin
         pop_check("drain_data", 8'h10 + 8'(i));
         check_level("drain", 4 - i);
      end
      check("drain_unf", unf, 0);

      // Wrap-around
      for (int i = 0; i < 3; i++) push(8'h01 + 8'(i));
      for (int i = 0; i < 3; i++) pop_check("pre_wrap", 8'h01 + 8'(i));
      for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
      check_level("wrap_full", 5);
      for (int i = 0; i < 5; i++) pop_check("wrap_data", 8'hA0 + 8'(i));
      check_level("wrap_empty", 0);

      // Concurrent read and write at level 2
      push(8'h30);
      push(8'h31);
      for (int i = 0; i < 10; i++) begin
         if (i == 0) check("rw_data", rd_data, 8'h30);
         else if (i == 1) check("rw_data", rd_data, 8'h31);
         else check("rw_data", rd_data, 8'h40 + 8'(i - 2));
         wr_en = 1; rd_en = 1; wr_data = 8'h40 + 8'(i);
         tick();
         check("rw_level", level, 2);
      end
      idle();
      pop_check("rw_tail", 8'h48);
      pop_check("rw_tail", 8'h49);

      // Full with read+write: write rejected, read taken
      for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
      wr_en = 1; rd_en = 1; wr_data = 8'hEE;
      tick();
      idle();
      check_level("full_rw", 4);
      check("full_rw_ovf", ovf, 1);
      check("full_rw_head", rd_data, 8'h51);
      err_clr = 1;
      tick();
      idle();
      check("ovf_clr", ovf, 0);
      for (int i = 1; i < 5; i++) pop_check("full_rw_data", 8'h50 + 8'(i));

      // Empty with read+write: read ignored, write taken
      wr_en = 1; rd_en = 1; wr_data = 8'h77;
      tick();
      idle();
      check_level("empty_rw", 1);
      check("empty_rw_unf", unf, 1);
      check("empty_rw_data", rd_data, 8'h77);
      err_clr = 1;
      tick();
      idle();
      check("unf_clr", unf, 0);
      pop_check("empty_rw_pop", 8'h77);

      // Flush with write at level 3
      for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
      check_level("pre_flush", 3);
      flush = 1; wr_en = 1; wr_data = 8'h99;
      tick();
      idle();
      check_level("flush", 0);
      check("flush_ovf", ovf, 0);
      push(8'h61);
      check("post_flush_data", rd_data, 8'h61);
      check_level("post_flush", 1);
      rd_en = 1;
      tick();
      idle();

      // Error clear loses to a same-cycle overflow
      for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
      wr_en = 1; wr_data = 8'hBB;
      tick();
      check("ovf_set", ovf, 1);
      err_clr = 1;
      tick();
      idle();
      check("ovf_set_wins", ovf, 1);
      check_level("ovf_keep", 5);
      flush = 1;
      tick();
      idle();
      check("ovf_after_flush", ovf, 1);
      check_level("flush_full", 0);

      // Asynchronous reset mid-cycle at level 4
      for (int i = 0; i < 4; i++) push(8'h80 + 8'(i));
      check_level("pre_reset", 4);
      #2 rst_n = 0;
      #1;
      check_level("async_reset", 0);
      check("async_reset_ovf", ovf, 0);
      check("async_reset_unf", unf, 0);
      #2 rst_n = 1;
      push(8'h5A);
      check("post_reset_data", rd_data, 8'h5A);
      check_level("post_reset", 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ucdp_sfifo.md
Name: ucdp_sfifo

Overview:
- Single-clock synchronous FIFO and the parametrised successor of the dual-clock FIFO.
- Supports an arbitrary depth (not only powers of two), an exact fill level, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.
- Read side is first-word-fall-through: the head word is presented while the FIFO is non-empty.
- Used inside one clock domain for rate smoothing between pipeline stages and bus adapters.

Parameters:
- dwidth_p, 8: data width in bits, >= 1.
- depth_p, 4: number of entries, >= 2, any integer.
- lwidth_p, $clog2(depth_p+1): width of level outputs. Must hold depth_p.
- afull_thresh_p, depth_p-1: almost_full asserts when level >= this value; range 1..depth_p.
- aempty_thresh_p, 1: almost_empty asserts when level <= this value; range 0..depth_p-1.

Ports:
- main_clk_i  input  1  clock.
- main_rst_an_i  input  1  async reset, active-low.
- flush_i  input  1  synchronous flush: drop all contents.
- err_clr_i  input  1  clear the sticky error flags.
- wr_en_i  input  1  write request.
- wr_data_i  input  dwidth_p  write data.
- full_o  output  1  FIFO full; registered.
- afull_o  output  1  almost full; registered.
- space_avail_o  output  lwidth_p  free entries; registered.
- rd_en_i  input  1  read request; pops the head word.
- rd_data_o  output  dwidth_p  head word; valid when empty_o=0.
- empty_o  output  1  FIFO empty; registered.
- aempty_o  output  1  almost empty; registered.
- level_o  output  lwidth_p  stored entries; registered.
- overflow_o  output  1  sticky: a write was attempted while full.
- underflow_o  output  1  sticky: a read was attempted while empty.

Behaviour:
- **Reset values:**
  - wr_ptr=0, rd_ptr=0, level=0.
  - full_o=0, empty_o=1, afull_o=0.
  - aempty_o=1 (since 0 <= aempty_thresh_p).
  - space_avail_o=depth_p, overflow_o=0, underflow_o=0.
  - rd_data_o is don't-care; the memory is not reset.
- **Storage:** memory of depth_p x dwidth_p. Pointers are $clog2(depth_p) bits and wrap explicitly from depth_p-1 to 0 (no power-of-two assumption). An internal level counter of lwidth_p bits disambiguates full from empty.
- **Accept rules:**
  - wr_acc = wr_en_i & ~full_o.
  - rd_acc = rd_en_i & ~empty_o.
  - Both are based on the registered flags only; a write into a full FIFO is rejected even if a read occurs in the same cycle.
- **Write:** on wr_acc, mem[wr_ptr] <= wr_data_i and wr_ptr advances with wrap.
- **Read:** rd_data_o = mem[rd_ptr] combinationally. On rd_acc, rd_ptr advances with wrap; the next word appears the following cycle.
- **Write-to-read latency:** 1 cycle. A word written at edge N gives empty_o=0 and valid rd_data_o after edge N.
- **Level update:**
  - level_next = level + wr_acc - rd_acc.
  - Simultaneous wr_acc and rd_acc leaves the level unchanged while both pointers advance.
- **Registered flags from level_next:**
  - full = (level_next == depth_p).
  - empty = (level_next == 0).
  - afull = (level_next >= afull_thresh_p).
  - aempty = (level_next <= aempty_thresh_p).
  - space_avail = depth_p - level_next.
  - level_o = level_next.
- **Errors:**
  - overflow_o sets on wr_en_i & full_o.
  - underflow_o sets on rd_en_i & empty_o.
  - err_clr_i clears both flags. If a set condition occurs in the same cycle as err_clr_i, set wins.
  - Error flags are unaffected by flush_i.
- **Flush:**
  - flush_i has priority over wr/rd in the same cycle. Pointers and level go to 0, flags take their reset values, and the write and read are both discarded.
  - The discarded write/read does not raise overflow/underflow.
- **Reset mid-operation:** immediate return to reset values; memory contents are lost logically.
- **Assertions (simulation only):**
  - Parameter range checks.
  - level_o <= depth_p at all times.
  - full_o and empty_o never both set.

Test Plan:
- **Fill/drain, non-power-of-two depth** (depth_p=5, dwidth_p=8): write 0x10..0x14 on consecutive cycles, then read 5 times -> full_o=1 after 5th write, level_o 1,2,3,4,5; rd_data_o 0x10..0x14 in order; empty_o=1 after 5th read.
- **Wrap-around:** 3 writes, 3 reads, then 5 writes of 0xA0..0xA4 -> pointers wrap past 4 to 0; reads return 0xA0..0xA4; full_o=1 at level 5.
- **Simultaneous rd/wr:**
  - At level 2, assert both for 10 cycles -> level_o stays 2; output order preserved.
  - When full, rd+wr -> write rejected, overflow_o=1, level 4.
  - When empty, rd+wr -> read ignored, underflow_o=1, level 1.
- **Thresholds** (afull_thresh_p=4, aempty_thresh_p=1):
  - Level 3->4 -> afull_o rises.
  - Level 2->1 -> aempty_o rises.
  - space_avail_o equals 5-level each cycle.
- **Flush and error clear:**
  - At level 3, flush_i together with wr_en_i -> level_o=0, empty_o=1, no overflow.
  - err_clr_i with an overflow set in the same cycle -> overflow_o stays 1.
- **Async reset at level 4:** deassert main_rst_an_i mid-cycle -> immediate empty_o=1, level_o=0, space_avail_o=5, flags 0; first write after release reads back correctly.
